// File: rtl/tdc_batch_sequencer.sv
// tdc_batch_sequencer: runs batches of TDC measurements in the launch domain.
// Each measurement toggles the pulse generator, waits a settle window, then
// folds the Hamming-weight readout into running sum/min/max. One result
// record per batch is offered through a valid/ready handshake.
module tdc_batch_sequencer #(
  parameter int HW_W   = 7,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 4,
  parameter int SUM_W  = HW_W + CNT_W
) (
  input  logic             clk_launch,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             abort,
  input  logic [HW_W-1:0]  hw_in,
  output logic             pg_out,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [HW_W-1:0]  res_min,
  output logic [HW_W-1:0]  res_max,
  output logic [CNT_W-1:0] res_count,
  output logic             res_aborted
);

  // Timer only ever holds SETTLE-1 down to 0.
  localparam int TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] n_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [HW_W-1:0]  min_reg;
  logic [HW_W-1:0]  max_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pg_reg;
  logic             valid_reg;
  logic             aborted_reg;

  // Batch sequencing, accumulation and result handshake.
  always_ff @(posedge clk_launch) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      n_reg       <= '0;
      timer_reg   <= '0;
      sum_reg     <= '0;
      min_reg     <= '1;
      max_reg     <= '0;
      count_reg   <= '0;
      pg_reg      <= 1'b0;
      valid_reg   <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // start has priority over abort; abort is meaningless here.
          if (start) begin
            n_reg       <= n_samples;
            sum_reg     <= '0;
            min_reg     <= '1;
            max_reg     <= '0;
            count_reg   <= '0;
            aborted_reg <= 1'b0;
            state_reg   <= (n_samples == '0) ? S_DONE : S_FIRE;
          end
        end
        S_FIRE: begin
          if (abort) begin
            // The pending toggle is suppressed.
            aborted_reg <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            pg_reg    <= ~pg_reg;
            timer_reg <= TMR_W'(SETTLE - 1);
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            aborted_reg <= 1'b1;
            state_reg   <= S_DONE;
          end else if (timer_reg == '0) begin
            state_reg <= S_SAMPLE;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            // Sample taken in the abort cycle is discarded.
            aborted_reg <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            sum_reg   <= sum_reg + SUM_W'(hw_in);
            count_reg <= count_reg + CNT_W'(1);
            if (hw_in < min_reg) min_reg <= hw_in;
            if (hw_in > max_reg) max_reg <= hw_in;
            state_reg <= ((count_reg + CNT_W'(1)) == n_reg) ? S_DONE : S_FIRE;
          end
        end
        S_DONE: begin
          // Valid rises one cycle after entering DONE, drops on handshake.
          if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (res_ready) begin
            valid_reg <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign pg_out      = pg_reg;
  assign busy        = (state_reg != S_IDLE);
  assign res_valid   = valid_reg;
  assign res_sum     = sum_reg;
  assign res_max     = max_reg;
  assign res_count   = count_reg;
  assign res_aborted = aborted_reg;
  // An empty batch reports 0 rather than the all-ones seed.
  assign res_min     = (count_reg == '0) ? '0 : min_reg;

endmodule

// File: tb/tb_tdc_batch_sequencer.sv
// Self-checking bench for tdc_batch_sequencer: scoreboard of expected result
// records, pushed when a batch is launched and popped when res_valid rises.
module tb_tdc_batch_sequencer;
  localparam int HW_W   = 7;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 4;
  localparam int SUM_W  = HW_W + CNT_W;
  localparam int P      = SETTLE + 2;

  logic             clk_launch = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic             abort = 1'b0;
  logic [HW_W-1:0]  hw_in = '0;
  logic             res_ready = 1'b1;
  logic             pg_out, busy, res_valid, res_aborted;
  logic [SUM_W-1:0] res_sum;
  logic [HW_W-1:0]  res_min, res_max;
  logic [CNT_W-1:0] res_count;

  typedef struct {
    int sum; int mn; int mx; int cnt; int ab; int lat; int tog;
  } exp_t;

  exp_t sb[$];
  int   hw_vals[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_launch = ~clk_launch;

  tdc_batch_sequencer #(
    .HW_W(HW_W), .CNT_W(CNT_W), .SETTLE(SETTLE), .SUM_W(SUM_W)
  ) dut (
    .clk_launch (clk_launch),
    .rst_n      (rst_n),
    .start      (start),
    .n_samples  (n_samples),
    .abort      (abort),
    .hw_in      (hw_in),
    .pg_out     (pg_out),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_min    (res_min),
    .res_max    (res_max),
    .res_count  (res_count),
    .res_aborted(res_aborted)
  );

  // Launch one batch of n samples from hw_vals; abort_at>0 asserts abort in
  // the cycle before start edge + abort_at. Compares the record on res_valid.
  task automatic do_batch(input string name, input int n, input int abort_at);
    exp_t e;
    int   done_cnt, rise, tog, idx;
    logic pg_prev;
    done_cnt = n;
    e.tog    = n;
    if (abort_at > 0) begin
      done_cnt = (abort_at - 1) / P;
      if (done_cnt > n) done_cnt = n;
      e.tog = (abort_at > 1) ? ((abort_at - 2) / P + 1) : 0;
      if (e.tog > n) e.tog = n;
    end
    e.sum = 0; e.mx = 0; e.mn = (1 << HW_W) - 1;
    for (int j = 0; j < done_cnt; j++) begin
      e.sum += hw_vals[j];
      if (hw_vals[j] < e.mn) e.mn = hw_vals[j];
      if (hw_vals[j] > e.mx) e.mx = hw_vals[j];
    end
    if (done_cnt == 0) e.mn = 0;
    e.cnt = done_cnt;
    e.ab  = (abort_at > 0) ? 1 : 0;
    e.lat = (abort_at > 0) ? abort_at + 1 : 1 + n * P;
    sb.push_back(e);

    @(negedge clk_launch);
    start = 1'b1;
    n_samples = CNT_W'(n);
    pg_prev = pg_out;
    tog = 0;
    @(posedge clk_launch);
    @(negedge clk_launch);
    start = 1'b0;
    rise = 0;
    for (int rel = 1; rel <= e.lat + 10 && rise == 0; rel++) begin
      idx = (rel - 1) / P;
      hw_in = (idx < hw_vals.size()) ? HW_W'(hw_vals[idx]) : '0;
      abort = (rel == abort_at);
      @(posedge clk_launch);
      @(negedge clk_launch);
      abort = 1'b0;
      if (pg_out !== pg_prev) begin
        tog++;
        pg_prev = pg_out;
      end
      if (res_valid === 1'b1) rise = rel;
    end

    e = sb.pop_front();
    n_vec++;
    if (rise !== e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, rise, e.lat);
    end
    n_vec++;
    if (res_sum !== SUM_W'(e.sum)) begin
      n_err++;
      $display("FAIL %s res_sum: got %0d expected %0d", name, res_sum, e.sum);
    end
    n_vec++;
    if (res_min !== HW_W'(e.mn)) begin
      n_err++;
      $display("FAIL %s res_min: got %0d expected %0d", name, res_min, e.mn);
    end
    n_vec++;
    if (res_max !== HW_W'(e.mx)) begin
      n_err++;
      $display("FAIL %s res_max: got %0d expected %0d", name, res_max, e.mx);
    end
    n_vec++;
    if (res_count !== CNT_W'(e.cnt)) begin
      n_err++;
      $display("FAIL %s res_count: got %0d expected %0d", name, res_count, e.cnt);
    end
    n_vec++;
    if (res_aborted !== e.ab[0]) begin
      n_err++;
      $display("FAIL %s res_aborted: got %0d expected %0d", name, res_aborted, e.ab);
    end
    n_vec++;
    if (tog !== e.tog) begin
      n_err++;
      $display("FAIL %s pg_toggles: got %0d expected %0d", name, tog, e.tog);
    end
    $display("batch %s: n=%0d abort_at=%0d lat=%0d sum=%0d min=%0d max=%0d cnt=%0d ab=%0d tog=%0d",
             name, n, abort_at, rise, res_sum, res_min, res_max, res_count, res_aborted, tog);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    n_samples = 8'd3;
    repeat (3) @(posedge clk_launch);
    @(negedge clk_launch);
    n_vec++;
    if ({busy, res_valid, pg_out, res_aborted} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got busy=%b valid=%b pg=%b ab=%b expected all 0",
               busy, res_valid, pg_out, res_aborted);
    end
    n_vec++;
    if (res_sum !== '0 || res_min !== '0 || res_max !== '0 || res_count !== '0) begin
      n_err++;
      $display("FAIL reset_res: got sum=%0d min=%0d max=%0d cnt=%0d expected all 0",
               res_sum, res_min, res_max, res_count);
    end
    $display("reset: busy=%b valid=%b pg=%b", busy, res_valid, pg_out);
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    hw_vals = '{10, 20, 5, 30};
    do_batch("basic_n4", 4, 0);
    @(posedge clk_launch);
    @(negedge clk_launch);
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_sum !== SUM_W'(65)) begin
      n_err++;
      $display("FAIL basic_after_ack: got valid=%b busy=%b sum=%0d expected 0 0 65",
               res_valid, busy, res_sum);
    end
  endtask

  task automatic test_zero();
    hw_vals = '{};
    do_batch("zero_n0", 0, 0);
    @(posedge clk_launch);
    @(negedge clk_launch);
  endtask

  task automatic test_abort();
    hw_vals = '{11, 22, 33, 44, 55, 66, 77, 88, 99, 100};
    do_batch("abort_wait", 10, 2 * P + 3);
    @(posedge clk_launch);
    @(negedge clk_launch);
    do_batch("abort_sample", 10, 3 * P);
    @(posedge clk_launch);
    @(negedge clk_launch);
    do_batch("abort_fire3", 10, 2 * P + 1);
    @(posedge clk_launch);
    @(negedge clk_launch);
    do_batch("abort_fire1", 10, 1);
    @(posedge clk_launch);
    @(negedge clk_launch);
  endtask

  task automatic test_backpressure();
    logic pg_hold;
    int   held_bad;
    hw_vals = '{40, 9};
    res_ready = 1'b0;
    do_batch("backpressure", 2, 0);
    pg_hold = pg_out;
    held_bad = 0;
    start = 1'b1;
    n_samples = 8'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_launch);
      @(negedge clk_launch);
      if (res_valid !== 1'b1 || busy !== 1'b1 || pg_out !== pg_hold ||
          res_sum !== SUM_W'(49) || res_count !== CNT_W'(2) || res_min !== HW_W'(9) ||
          res_max !== HW_W'(40)) held_bad++;
    end
    n_vec++;
    if (held_bad !== 0) begin
      n_err++;
      $display("FAIL backpressure_hold: got %0d bad cycles expected 0", held_bad);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk_launch);
    @(negedge clk_launch);
    n_vec++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release: got valid=%b busy=%b expected 0 0", res_valid, busy);
    end
    @(posedge clk_launch);
    @(negedge clk_launch);
    n_vec++;
    if (busy !== 1'b0 || pg_out !== pg_hold) begin
      n_err++;
      $display("FAIL backpressure_no_queue: got busy=%b pg=%b expected 0 %b", busy, pg_out, pg_hold);
    end
    $display("backpressure: held_bad=%0d busy=%b", held_bad, busy);
  endtask

  task automatic test_max_batch();
    hw_vals = '{};
    for (int j = 0; j < 255; j++) hw_vals.push_back(127);
    do_batch("max_n255", 255, 0);
    @(posedge clk_launch);
    @(negedge clk_launch);
  endtask

  task automatic test_reset_mid_wait();
    int valid_seen;
    hw_vals = '{50};
    @(negedge clk_launch);
    hw_in = 7'd50;
    start = 1'b1;
    n_samples = 8'd3;
    @(posedge clk_launch);
    @(negedge clk_launch);
    start = 1'b0;
    repeat (2) @(posedge clk_launch);
    @(negedge clk_launch);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midwait_running: got busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk_launch);
    @(negedge clk_launch);
    rst_n = 1'b1;
    n_vec++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || pg_out !== 1'b0 || res_count !== '0) begin
      n_err++;
      $display("FAIL midwait_reset: got busy=%b valid=%b pg=%b cnt=%0d expected 0 0 0 0",
               busy, res_valid, pg_out, res_count);
    end
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_launch);
      @(negedge clk_launch);
      if (res_valid !== 1'b0 || busy !== 1'b0) valid_seen++;
    end
    n_vec++;
    if (valid_seen !== 0) begin
      n_err++;
      $display("FAIL midwait_no_result: got %0d active cycles expected 0", valid_seen);
    end
    $display("reset_mid_wait: busy=%b valid=%b active_after=%0d", busy, res_valid, valid_seen);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_backpressure();
    test_max_batch();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
